baccarat_round_fsm: RTL and testbench

//  Parametrised successor to the single-hand baccarat dealer FSM. Sequences
//  the deal (P1,D1,P2,D2), natural check, full tableau third-card rules and
//  the result for ROUNDS consecutive hands per start.

---
 rtl/baccarat_pkg.sv | 41 ++++
 rtl/baccarat_round_fsm_if.sv | 32 +++
 rtl/baccarat_tally.sv | 51 +++++
 rtl/baccarat_round_fsm.sv | 134 +++++++++++++
 tb/tb_baccarat_round_fsm.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/baccarat_pkg.sv
// Shared types, thresholds and the dealer third-card rule
// for the multi-round baccarat dealer.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_EVAL,
    S_P3,
    S_CHK3,
    S_D3,
    S_RESULT
  } state_t;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] DEALER_STAND    = 4'd7;

  function automatic logic dealer_draws(
    input logic [3:0] dscore,
    input logic [3:0] pcard3
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (dscore <= 4'd2): r = 1'b1;
      (dscore == 4'd3): r = (pcard3 != 4'd8);
      (dscore == 4'd4): r = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      (dscore == 4'd5): r = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      (dscore == 4'd6): r = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      (dscore >= DEALER_STAND): r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/baccarat_round_fsm_if.sv
// Card-source handshake and score datapath bundle between
// the dealer FSM (master) and the card/score datapath (slave).
interface baccarat_round_fsm_if;

  logic       card_valid;
  logic       req_card;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       clear_hand;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;

  modport master (
    input  card_valid, pscore, dscore, pcard3,
    output req_card, clear_hand,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3
  );

  modport slave (
    output card_valid, pscore, dscore, pcard3,
    input  req_card, clear_hand,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3
  );

endinterface

// File: rtl/baccarat_tally.sv
// Saturating player/dealer/tie win counters, bumped once per
// completed hand; cleared only by reset.
module baccarat_tally
  import baccarat_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             p_gt,
  input  logic             d_gt,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties
);

  logic [CNT_W-1:0] pw_q, pw_d;
  logic [CNT_W-1:0] dw_q, dw_d;
  logic [CNT_W-1:0] ti_q, ti_d;

  always_comb begin
    pw_d = pw_q;
    dw_d = dw_q;
    ti_d = ti_q;
    if (en) begin
      unique case (1'b1)
        p_gt:    pw_d = (&pw_q) ? pw_q : pw_q + 1'b1;
        d_gt:    dw_d = (&dw_q) ? dw_q : dw_q + 1'b1;
        default: ti_d = (&ti_q) ? ti_q : ti_q + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_q <= '0;
      dw_q <= '0;
      ti_q <= '0;
    end else begin
      pw_q <= pw_d;
      dw_q <= dw_d;
      ti_q <= ti_d;
    end
  end

  assign player_wins = pw_q;
  assign dealer_wins = dw_q;
  assign ties        = ti_q;

endmodule

// File: rtl/baccarat_round_fsm.sv
// Baccarat dealer sequencing ROUNDS hands per start pulse.
// Define BACCARAT_TALLY_EN to enable persistent win tallies.
module baccarat_round_fsm
  import baccarat_pkg::*;
#(
  parameter int ROUNDS = 1,
  parameter int CNT_W  = 8
) (
  input  logic                   slow_clock,
  input  logic                   resetb,
  input  logic                   start,
  baccarat_round_fsm_if.master   dp,
  output logic                   player_win_light,
  output logic                   dealer_win_light,
  output logic                   hand_done,
  output logic                   game_done,
  output logic [CNT_W-1:0]       round_cnt,
  output logic [CNT_W-1:0]       player_wins,
  output logic [CNT_W-1:0]       dealer_wins,
  output logic [CNT_W-1:0]       ties
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             pwin_q, pwin_d;
  logic             dwin_q, dwin_d;
  logic             last;
  logic [3:0]       ps, ds;

  assign ps      = dp.pscore;
  assign ds      = dp.dscore;
  assign cnt_inc = round_cnt_q + 1'b1;
  assign last    = (cnt_inc == CNT_W'(ROUNDS));

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    pwin_d      = pwin_q;
    dwin_d      = dwin_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLR;
          round_cnt_d = '0;
          pwin_d      = 1'b0;
          dwin_d      = 1'b0;
        end
      end
      S_CLR: begin
        state_d = S_P1;
        pwin_d  = 1'b0;
        dwin_d  = 1'b0;
      end
      S_P1: if (dp.card_valid) state_d = S_D1;
      S_D1: if (dp.card_valid) state_d = S_P2;
      S_P2: if (dp.card_valid) state_d = S_D2;
      S_D2: if (dp.card_valid) state_d = S_EVAL;
      S_EVAL: begin
        if (ps >= NATURAL_MIN || ds >= NATURAL_MIN)
          state_d = S_RESULT;
        else if (ps <= PLAYER_DRAW_MAX)
          state_d = S_P3;
        // standing player: dealer uses the same 0..5 draw band
        else if (ds <= PLAYER_DRAW_MAX)
          state_d = S_D3;
        else
          state_d = S_RESULT;
      end
      S_P3: if (dp.card_valid) state_d = S_CHK3;
      S_CHK3: begin
        state_d = dealer_draws(ds, dp.pcard3) ? S_D3 : S_RESULT;
      end
      S_D3: if (dp.card_valid) state_d = S_RESULT;
      S_RESULT: begin
        pwin_d      = (ps >= ds);
        dwin_d      = (ds >= ps);
        round_cnt_d = cnt_inc;
        state_d     = last ? S_IDLE : S_CLR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= S_IDLE;
      round_cnt_q <= '0;
      pwin_q      <= 1'b0;
      dwin_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      pwin_q      <= pwin_d;
      dwin_q      <= dwin_d;
    end
  end

  assign dp.req_card = state_q inside
    {S_P1, S_D1, S_P2, S_D2, S_P3, S_D3};
  assign dp.clear_hand  = (state_q == S_CLR);
  assign dp.load_pcard1 = (state_q == S_P1) & dp.card_valid;
  assign dp.load_dcard1 = (state_q == S_D1) & dp.card_valid;
  assign dp.load_pcard2 = (state_q == S_P2) & dp.card_valid;
  assign dp.load_dcard2 = (state_q == S_D2) & dp.card_valid;
  assign dp.load_pcard3 = (state_q == S_P3) & dp.card_valid;
  assign dp.load_dcard3 = (state_q == S_D3) & dp.card_valid;

  assign hand_done        = (state_q == S_RESULT);
  assign game_done        = hand_done & last;
  assign round_cnt        = round_cnt_q;
  assign player_win_light = pwin_q;
  assign dealer_win_light = dwin_q;

`ifdef BACCARAT_TALLY_EN
  baccarat_tally #(
    .CNT_W(CNT_W)
  ) u_tally (
    .clk         (slow_clock),
    .rst_n       (resetb),
    .en          (hand_done),
    .p_gt        (ps > ds),
    .d_gt        (ds > ps),
    .player_wins (player_wins),
    .dealer_wins (dealer_wins),
    .ties        (ties)
  );
`else
  assign player_wins = '0;
  assign dealer_wins = '0;
  assign ties        = '0;
`endif

endmodule

// File: tb/tb_baccarat_round_fsm.sv
// Directed bench: single-hand dealer (ROUNDS=1) and a
// three-hand game instance (ROUNDS=3, CNT_W=2).
module tb_baccarat_round_fsm;

`ifdef BACCARAT_TALLY_EN
  localparam bit TALLY = 1'b1;
`else
  localparam bit TALLY = 1'b0;
`endif

  logic clk, rst_n;
  logic start1, start3;

  logic       pl1, dl1, hd1, gd1;
  logic [7:0] rc1, pw1, dw1, ti1;
  logic       pl3, dl3, hd3, gd3;
  logic [1:0] rc3, pw3, dw3, ti3;

  int vecs = 0;
  int errs = 0;

  int n_ld = 0, n_p3 = 0, n_d3 = 0;
  int n_clr = 0, n_hd = 0, n_gd = 0;
  int m_clr = 0, m_hd = 0, m_gd = 0;

  baccarat_round_fsm_if b1();
  baccarat_round_fsm_if b3();

  baccarat_round_fsm #(.ROUNDS(1), .CNT_W(8)) u1 (
    .slow_clock       (clk),
    .resetb           (rst_n),
    .start            (start1),
    .dp               (b1.master),
    .player_win_light (pl1),
    .dealer_win_light (dl1),
    .hand_done        (hd1),
    .game_done        (gd1),
    .round_cnt        (rc1),
    .player_wins      (pw1),
    .dealer_wins      (dw1),
    .ties             (ti1)
  );

  baccarat_round_fsm #(.ROUNDS(3), .CNT_W(2)) u3 (
    .slow_clock       (clk),
    .resetb           (rst_n),
    .start            (start3),
    .dp               (b3.master),
    .player_win_light (pl3),
    .dealer_win_light (dl3),
    .hand_done        (hd3),
    .game_done        (gd3),
    .round_cnt        (rc3),
    .player_wins      (pw3),
    .dealer_wins      (dw3),
    .ties             (ti3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_ld += int'(b1.load_pcard1) + int'(b1.load_dcard1)
          + int'(b1.load_pcard2) + int'(b1.load_dcard2)
          + int'(b1.load_pcard3) + int'(b1.load_dcard3);
    if (b1.load_pcard3) n_p3++;
    if (b1.load_dcard3) n_d3++;
    if (b1.clear_hand)  n_clr++;
    if (hd1)            n_hd++;
    if (gd1)            n_gd++;
    if (b3.clear_hand)  m_clr++;
    if (hd3)            m_hd++;
    if (gd3)            m_gd++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic play1(
    input  logic [3:0] p, d, c3,
    output bit ok, output int cyc,
    output int dld, output int dp3, output int dd3,
    output int dhd, output int dgd
  );
    int l0, p0, d0, h0, g0;
    l0 = n_ld; p0 = n_p3; d0 = n_d3;
    h0 = n_hd; g0 = n_gd;
    b1.pscore = p; b1.dscore = d; b1.pcard3 = c3;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    b1.card_valid = 1'b1;
    ok = 1'b0;
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gd1) begin
        ok = 1'b1;
        cyc = i;
        break;
      end
    end
    tick();
    b1.card_valid = 1'b0;
    dld = n_ld - l0; dp3 = n_p3 - p0; dd3 = n_d3 - d0;
    dhd = n_hd - h0; dgd = n_gd - g0;
  endtask

  task automatic play3(
    input  logic [3:0] p, d,
    output bit ok, output int dhd,
    output int dclr, output int dgd
  );
    int h0, c0, g0;
    h0 = m_hd; c0 = m_clr; g0 = m_gd;
    b3.pscore = p; b3.dscore = d; b3.pcard3 = 4'd0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    b3.card_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (gd3) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    b3.card_valid = 1'b0;
    dhd = m_hd - h0; dclr = m_clr - c0; dgd = m_gd - g0;
  endtask

  task automatic test_reset();
    logic [11:0] ctl;
    int l0;
    rst_n = 1'b0;
    b1.card_valid = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    ctl = {b1.req_card, b1.clear_hand, b1.load_pcard1,
           b1.load_dcard1, b1.load_pcard2, b1.load_dcard2,
           b1.load_pcard3, b1.load_dcard3, pl1, dl1, hd1, gd1};
    vecs++;
    if (ctl !== 12'd0) begin
      errs++;
      $display("FAIL reset_ctl: got %b want 0", ctl);
    end
    vecs++;
    if ({rc1, pw1, dw1, ti1} !== 32'd0) begin
      errs++;
      $display("FAIL reset_cnt: got %h want 0",
               {rc1, pw1, dw1, ti1});
    end
    vecs++;
    if ({rc3, pl3, dl3, hd3, gd3, b3.req_card} !== 7'd0) begin
      errs++;
      $display("FAIL reset_u3: got %b want 0",
               {rc3, pl3, dl3, hd3, gd3, b3.req_card});
    end
    tick();
    rst_n = 1'b1;
    l0 = n_ld;
    repeat (4) tick();
    @(negedge clk);
    vecs++;
    if ({b1.req_card, 32'(n_ld - l0)} !== 33'd0) begin
      errs++;
      $display("FAIL idle_no_start: req %b loads %0d want 0 0",
               b1.req_card, n_ld - l0);
    end
    b1.card_valid = 1'b0;
    tick();
  endtask

  task automatic test_natural();
    bit ok; int cyc, ld, p3, d3, hd, gd;
    play1(4'd9, 4'd3, 4'd0, ok, cyc, ld, p3, d3, hd, gd);
    vecs++;
    if (!ok || cyc != 6) begin
      errs++;
      $display("FAIL nat_latency: got %0d want 6", cyc);
    end
    vecs++;
    if (ld != 4 || p3 != 0 || d3 != 0) begin
      errs++;
      $display("FAIL nat_loads: got %0d/%0d/%0d want 4/0/0",
               ld, p3, d3);
    end
    vecs++;
    if ({pl1, dl1} !== 2'b10 || rc1 !== 8'd1) begin
      errs++;
      $display("FAIL nat_result: lights %b cnt %0d want 10 1",
               {pl1, dl1}, rc1);
    end
    vecs++;
    if (hd != 1 || gd != 1) begin
      errs++;
      $display("FAIL nat_pulses: hd %0d gd %0d want 1 1", hd, gd);
    end
  endtask

  task automatic test_player_draw();
    bit ok; int cyc, ld, p3, d3, hd, gd;
    play1(4'd4, 4'd5, 4'd6, ok, cyc, ld, p3, d3, hd, gd);
    vecs++;
    if (!ok || cyc != 9 || ld != 6 || p3 != 1 || d3 != 1) begin
      errs++;
      $display("FAIL draw_both: cyc %0d ld %0d p3 %0d d3 %0d want 9 6 1 1",
               cyc, ld, p3, d3);
    end
    vecs++;
    if ({pl1, dl1} !== 2'b01) begin
      errs++;
      $display("FAIL draw_both_light: got %b want 01", {pl1, dl1});
    end
    play1(4'd4, 4'd5, 4'd8, ok, cyc, ld, p3, d3, hd, gd);
    vecs++;
    if (!ok || cyc != 8 || ld != 5 || p3 != 1 || d3 != 0) begin
      errs++;
      $display("FAIL draw_p_only: cyc %0d ld %0d p3 %0d d3 %0d want 8 5 1 0",
               cyc, ld, p3, d3);
    end
  endtask

  task automatic test_dealer_rule();
    bit ok; int cyc, ld, p3, d3, hd, gd;
    int td[10] = '{2, 3, 3, 4, 4, 5, 5, 6, 6, 7};
    int tc[10] = '{8, 8, 9, 1, 7, 3, 4, 5, 6, 6};
    int te[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    for (int k = 0; k < 10; k++) begin
      play1(4'd0, 4'(td[k]), 4'(tc[k]), ok, cyc, ld, p3, d3, hd, gd);
      vecs++;
      if (!ok || d3 != te[k]) begin
        errs++;
        $display("FAIL rule_d%0d_c%0d: d3 %0d want %0d",
                 td[k], tc[k], d3, te[k]);
      end
    end
  endtask

  task automatic test_stand_draw();
    bit ok; int cyc, ld, p3, d3, hd, gd;
    play1(4'd7, 4'd4, 4'd0, ok, cyc, ld, p3, d3, hd, gd);
    vecs++;
    if (!ok || cyc != 7 || p3 != 0 || d3 != 1) begin
      errs++;
      $display("FAIL stand_d3: cyc %0d p3 %0d d3 %0d want 7 0 1",
               cyc, p3, d3);
    end
    vecs++;
    if ({pl1, dl1} !== 2'b10) begin
      errs++;
      $display("FAIL stand_light: got %b want 10", {pl1, dl1});
    end
    play1(4'd6, 4'd6, 4'd0, ok, cyc, ld, p3, d3, hd, gd);
    vecs++;
    if (!ok || cyc != 6 || ld != 4) begin
      errs++;
      $display("FAIL tie_flow: cyc %0d ld %0d want 6 4", cyc, ld);
    end
    vecs++;
    if ({pl1, dl1} !== 2'b11) begin
      errs++;
      $display("FAIL tie_light: got %b want 11", {pl1, dl1});
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int l0, bad;
    l0 = n_ld;
    b1.pscore = 4'd9; b1.dscore = 4'd0; b1.pcard3 = 4'd0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    vecs++;
    if ({pl1, dl1} !== 2'b00) begin
      errs++;
      $display("FAIL light_clear: got %b want 00", {pl1, dl1});
    end
    b1.card_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b1.load_dcard1) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    b1.card_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!b1.req_card || b1.load_pcard2) bad++;
    end
    vecs++;
    if (!ok || bad != 0 || n_ld - l0 != 2) begin
      errs++;
      $display("FAIL stall: bad %0d loads %0d want 0 2",
               bad, n_ld - l0);
    end
    tick();
    b1.card_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gd1) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    b1.card_valid = 1'b0;
    vecs++;
    if (!ok || n_ld - l0 != 4 || {pl1, dl1} !== 2'b10) begin
      errs++;
      $display("FAIL stall_resume: loads %0d lights %b want 4 10",
               n_ld - l0, {pl1, dl1});
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc, ld, p3, d3, hd, gd;
    int l0;
    logic [3:0] ctl;
    b1.pscore = 4'd4; b1.dscore = 4'd5; b1.pcard3 = 4'd6;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    b1.card_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b1.load_dcard2) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    b1.card_valid = 1'b0;
    tick();
    @(negedge clk);
    b1.card_valid = 1'b1;
    #1;
    vecs++;
    if (!ok || {b1.req_card, b1.load_pcard3} !== 2'b11) begin
      errs++;
      $display("FAIL p3_entry: got %b want 11",
               {b1.req_card, b1.load_pcard3});
    end
    #1 rst_n = 1'b0;
    #1;
    ctl = {b1.req_card, b1.load_pcard3, hd1, gd1};
    vecs++;
    if (ctl !== 4'd0 || rc1 !== 8'd0) begin
      errs++;
      $display("FAIL async_reset: ctl %b cnt %0d want 0 0", ctl, rc1);
    end
    tick();
    rst_n = 1'b1;
    l0 = n_ld;
    repeat (5) tick();
    @(negedge clk);
    vecs++;
    if (b1.req_card !== 1'b0 || n_ld != l0) begin
      errs++;
      $display("FAIL post_reset_idle: req %b loads %0d want 0 0",
               b1.req_card, n_ld - l0);
    end
    b1.card_valid = 1'b0;
    tick();
    play1(4'd9, 4'd3, 4'd0, ok, cyc, ld, p3, d3, hd, gd);
    vecs++;
    if (!ok || gd != 1 || rc1 !== 8'd1) begin
      errs++;
      $display("FAIL restart: gd %0d cnt %0d want 1 1", gd, rc1);
    end
  endtask

  task automatic test_rounds();
    bit ok; int hd, clr, gd;
    logic [1:0] et;
    play3(4'd9, 4'd3, ok, hd, clr, gd);
    vecs++;
    if (!ok || hd != 3 || clr != 3 || gd != 1) begin
      errs++;
      $display("FAIL rounds3: hd %0d clr %0d gd %0d want 3 3 1",
               hd, clr, gd);
    end
    vecs++;
    if (rc3 !== 2'd3 || {pl3, dl3} !== 2'b10) begin
      errs++;
      $display("FAIL rounds3_out: cnt %0d lights %b want 3 10",
               rc3, {pl3, dl3});
    end
    et = TALLY ? 2'd3 : 2'd0;
    vecs++;
    if ({pw3, dw3, ti3} !== {et, 2'd0, 2'd0}) begin
      errs++;
      $display("FAIL tally_g1: got %b want %b",
               {pw3, dw3, ti3}, {et, 4'd0});
    end
    play3(4'd3, 4'd9, ok, hd, clr, gd);
    play3(4'd9, 4'd3, ok, hd, clr, gd);
    play3(4'd5, 4'd5, ok, hd, clr, gd);
    vecs++;
    if (!ok || {pw3, dw3, ti3} !== {et, et, et}) begin
      errs++;
      $display("FAIL tally_sat: got %b want %b",
               {pw3, dw3, ti3}, {et, et, et});
    end
    vecs++;
    if ({pl3, dl3} !== 2'b11 || rc3 !== 2'd3) begin
      errs++;
      $display("FAIL rounds_tie: lights %b cnt %0d want 11 3",
               {pl3, dl3}, rc3);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    b1.card_valid = 1'b0;
    b1.pscore = 4'd0; b1.dscore = 4'd0; b1.pcard3 = 4'd0;
    b3.card_valid = 1'b0;
    b3.pscore = 4'd0; b3.dscore = 4'd0; b3.pcard3 = 4'd0;
    test_reset();
    test_natural();
    test_player_draw();
    test_dealer_rule();
    test_stand_draw();
    test_backpressure();
    test_reset_mid();
    test_rounds();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
